// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with a single-cycle request and one-cycle completion pulse.
// Optional build macro ITER_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module iter_div #(
  parameter int unsigned N_BITS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              signed_i,
  input  logic              in_valid_i,
  output logic              ready_o,
  output logic [N_BITS-1:0] q_o,
  output logic [N_BITS-1:0] r_o,
  output logic              valid_o
);

  localparam int unsigned CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [N_BITS-1:0] MIN_NEG = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [N_BITS-1:0] dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [N_BITS-1:0] dvs_q;
  logic [N_BITS-1:0] rem_q;
  logic [N_BITS-1:0] a_raw_q;
  logic [CW-1:0]     cnt_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              div0_q;
  logic              ovf_q;

  logic              accept;
  logic              last_iter;
  logic [N_BITS-1:0] a_abs;
  logic [N_BITS-1:0] b_abs;
  logic              in_b_zero;
  logic              in_ovf;
  logic [N_BITS:0]   part;
  logic              ge;
  logic [N_BITS-1:0] rem_nx;
  logic [N_BITS-1:0] quo_nx;
  logic [N_BITS-1:0] q_fin;
  logic [N_BITS-1:0] r_fin;

  assign accept    = (state_q == S_IDLE) && in_valid_i;
  assign last_iter = (state_q == S_ITER) && (cnt_q == LAST_CNT);

  assign a_abs     = (signed_i && a_i[N_BITS-1]) ? (~a_i + 1'b1) : a_i;
  assign b_abs     = (signed_i && b_i[N_BITS-1]) ? (~b_i + 1'b1) : b_i;
  assign in_b_zero = (b_i == '0);
  assign in_ovf    = signed_i && (a_i == MIN_NEG) && (b_i == '1);

  // The remainder after a successful subtract is below the divisor, so N-bit arithmetic suffices.
  always_comb begin
    part   = {rem_q, dvd_q[N_BITS-1]};
    ge     = (part >= {1'b0, dvs_q});
    rem_nx = ge ? (part[N_BITS-1:0] - dvs_q) : part[N_BITS-1:0];
    quo_nx = {dvd_q[N_BITS-2:0], ge};
  end

  always_comb begin
    q_fin = q_neg_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fin = r_neg_q ? (~rem_nx + 1'b1) : rem_nx;
    if (div0_q) begin
      q_fin = '1;
      r_fin = a_raw_q;
    end else if (ovf_q) begin
      q_fin = MIN_NEG;
      r_fin = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (in_valid_i) begin
`ifdef ITER_DIV_EARLY_OUT_EN
          state_d = (in_b_zero || in_ovf) ? S_DONE : S_ITER;
`else
          state_d = S_ITER;
`endif
        end
      end
      S_ITER: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      a_raw_q <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      q_o     <= '0;
      r_o     <= '0;
    end else if (accept) begin
      dvd_q   <= a_abs;
      dvs_q   <= b_abs;
      rem_q   <= '0;
      a_raw_q <= a_i;
      cnt_q   <= '0;
      q_neg_q <= signed_i && (a_i[N_BITS-1] ^ b_i[N_BITS-1]);
      r_neg_q <= signed_i && a_i[N_BITS-1];
      div0_q  <= in_b_zero;
      ovf_q   <= in_ovf;
`ifdef ITER_DIV_EARLY_OUT_EN
      if (in_b_zero) begin
        q_o <= '1;
        r_o <= a_i;
      end else if (in_ovf) begin
        q_o <= MIN_NEG;
        r_o <= '0;
      end
`endif
    end else if (state_q == S_ITER) begin
      rem_q <= rem_nx;
      dvd_q <= quo_nx;
      if (last_iter) begin
        cnt_q <= '0;
        q_o   <= q_fin;
        r_o   <= r_fin;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/iter_div.md
# iter_div

Iterative radix-2 restoring divider that is the responder side of the functional unit's divide handshake. It accepts one dividend/divisor pair on a single-cycle request, computes quotient and remainder over `N_BITS` iterations, and returns both with a one-cycle completion pulse. It sits inside the PE functional unit and serves the DIV and DIVU instructions.

## Interface

- `N_BITS`, default 32: operand, quotient and remainder width.
- `clk_i` input, 1 bit: clock. All state changes on the rising edge.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `a_i` input, `N_BITS`: dividend.
- `b_i` input, `N_BITS`: divisor.
- `signed_i` input, 1 bit: 1 selects DIV (two's complement), 0 selects DIVU.
- `in_valid_i` input, 1 bit: request. Sampled together with `ready_o`.
- `ready_o` output, 1 bit: block is idle and can accept a request.
- `q_o` output, `N_BITS`: quotient. Registered and held until the next completion.
- `r_o` output, `N_BITS`: remainder. Registered and held until the next completion.
- `valid_o` output, 1 bit: completion pulse, high for exactly one cycle.

## Operation

- **States:** IDLE, ITER, DONE.
- **Reset values:** state = IDLE, `ready_o` = 1, `valid_o` = 0, `q_o` = 0, `r_o` = 0, iteration counter = 0.
- **IDLE**
  - `ready_o` = 1.
  - If `in_valid_i` is high, the block captures |a|, |b|, the quotient sign (`signed_i` & (a[MSB] ^ b[MSB])), the remainder sign (`signed_i` & a[MSB]) and the special-case flags, then moves to ITER.
  - For DIVU the absolute value is the raw operand.
- **ITER**
  - `ready_o` = 0.
  - Each cycle: partial remainder (`N_BITS`+1 bits) = {rem, next dividend MSB}. If it is ≥ |b|, subtract and shift in quotient bit 1; otherwise shift in 0.
  - The counter runs 0..`N_BITS`-1. On the last iteration the block applies the sign fixup and special cases, registers `q_o`/`r_o`, and moves to DONE.
- **DONE**
  - `valid_o` = 1 and `ready_o` = 0 for one cycle, then IDLE.
- **Sign fixup:** truncation toward zero. The quotient is negated when the quotient sign is set. The remainder is negated when the remainder sign is set, so the remainder takes the sign of the dividend.
- **Special cases:** these override the iteration result.
  - b = 0: `q_o` = all ones, `r_o` = a_i as captured. Applies to both signed and unsigned.
  - Signed, a = most-negative value, b = -1: `q_o` = most-negative value, `r_o` = 0.
- **Request while busy:** an `in_valid_i` seen in ITER or DONE is ignored and dropped. It has no effect on the operation in flight. The requester must hold or re-issue its request.
- **Operand stability:** `a_i`, `b_i` and `signed_i` are only sampled in the acceptance cycle. Later changes have no effect.

## Timing

- **Acceptance:** a request is accepted in cycle 0 when `in_valid_i` = 1 and `ready_o` = 1.
- **Latency:** `valid_o` = 1 in cycle `N_BITS`+1 (cycle 33 for `N_BITS` = 32). `q_o`/`r_o` are valid in that cycle and stay stable afterwards.
- **Throughput:** `ready_o` returns to 1 in cycle `N_BITS`+2. The earliest next acceptance is cycle `N_BITS`+2, giving one operation per `N_BITS`+2 cycles.
- **Reset in any state:** next cycle state = IDLE, `valid_o` = 0, `q_o`/`r_o` = 0. The in-flight operation is discarded and produces no pulse.
- **Reset and `in_valid_i` in the same cycle:** reset wins and the request is not accepted.

## Configuration

- **`ITER_DIV_EARLY_OUT_EN` defined**
  - Special cases (b = 0, signed overflow) skip ITER and go IDLE → DONE.
  - `valid_o` is high in cycle 1 and `ready_o` returns in cycle 2.
  - All other operations keep `N_BITS`+1 latency.
- **Not defined**
  - Every operation, including special cases, takes exactly `N_BITS`+1 cycles.
  - Special-case results are identical in both builds.

## Test plan

- **Unsigned divide:** DIVU a=100, b=7, request in cycle 0 → `valid_o` is a single pulse in cycle 33 with `q_o`=14, `r_o`=2. `ready_o`=0 in cycles 1–33 and 1 in cycle 34.
- **Signed, negative dividend:** DIV a=-7 (0xFFFFFFF9), b=2 → `q_o`=0xFFFFFFFD (-3), `r_o`=0xFFFFFFFF (-1).
- **Signed, negative divisor:** DIV a=7, b=-2 → `q_o`=-3, `r_o`=1.
- **Divide by zero:** DIVU a=5, b=0 → `q_o`=0xFFFFFFFF, `r_o`=5. Latency is 33 without `ITER_DIV_EARLY_OUT_EN` and 1 with it.
- **Signed overflow:** DIV a=0x80000000, b=0xFFFFFFFF → `q_o`=0x80000000, `r_o`=0.
- **Request while busy, then reset:** a second request at cycle 5 with a=9, b=3 is ignored and the first result is delivered unchanged. Then start a new operation and assert `rst_i` in cycle 10 → no `valid_o` pulse, `q_o`=`r_o`=0, `ready_o`=1 in cycle 11.
